// File: rtl/apb_rr_arbiter_if.sv
// Bundle for the requester handshakes and the shared APB master port of apb_rr_arbiter.
// The master modport is the arbiter's view; slave is the environment (requesters + APB slave).
interface apb_rr_arbiter_if #(
  parameter int unsigned NREQ = 2,
  parameter int unsigned AW   = 32,
  parameter int unsigned DW   = 32
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_write;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_wdata;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ-1:0]    rsp_valid;
  logic [DW-1:0]      rsp_rdata;
  logic               rsp_err;

  logic               PSEL;
  logic               PENABLE;
  logic               PWRITE;
  logic [AW-1:0]      PADDR;
  logic [DW-1:0]      PWDATA;
  logic [DW-1:0]      PRDATA;
  logic               PREADY;
  logic               PSLVERR;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, PRDATA, PREADY, PSLVERR,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, PSEL, PENABLE, PWRITE, PADDR, PWDATA
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, PRDATA, PREADY, PSLVERR,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, PSEL, PENABLE, PWRITE, PADDR, PWDATA
  );
endinterface

// File: rtl/apb_rr_arbiter.sv
// Round-robin scheduler sharing one APB master port among NREQ requesters,
// with SETUP/ACCESS sequencing, wait states, PSLVERR and an optional ACCESS watchdog.
module apb_rr_arbiter #(
  parameter int unsigned NREQ    = 2,
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                PCLK,
  input  logic                PRESET,
  apb_rr_arbiter_if.master    bus
);

  localparam int unsigned GW      = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CW      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned TO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t            state_q, state_d;
  logic              psel_q, psel_d;
  logic              penable_q, penable_d;
  logic              pwrite_q, pwrite_d;
  logic [AW-1:0]     paddr_q, paddr_d;
  logic [DW-1:0]     pwdata_q, pwdata_d;
  logic [NREQ-1:0]   req_ready_q, req_ready_d;
  logic [NREQ-1:0]   rsp_valid_q, rsp_valid_d;
  logic [DW-1:0]     rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic [CW-1:0]     wait_q, wait_d;
  logic [GW-1:0]     last_grant_q, last_grant_d;

  logic [AW-1:0]     addr_arr  [NREQ];
  logic [DW-1:0]     wdata_arr [NREQ];
  logic              any_req;
  logic [GW-1:0]     grant_idx;
  int unsigned       cand;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign addr_arr[gi]  = bus.req_addr[gi*AW +: AW];
    assign wdata_arr[gi] = bus.req_wdata[gi*DW +: DW];
  end

  // First pending requester searching upward from the one after the last grant.
  always_comb begin
    any_req   = 1'b0;
    grant_idx = last_grant_q;
    cand      = 0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      cand = (32'(last_grant_q) + 32'd1 + i) % NREQ;
      if (!any_req && bus.req_valid[GW'(cand)]) begin
        any_req   = 1'b1;
        grant_idx = GW'(cand);
      end
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d      = state_q;
    psel_d       = psel_q;
    penable_d    = penable_q;
    pwrite_d     = pwrite_q;
    paddr_d      = paddr_q;
    pwdata_d     = pwdata_q;
    req_ready_d  = '0;
    rsp_valid_d  = '0;
    rsp_rdata_d  = rsp_rdata_q;
    rsp_err_d    = rsp_err_q;
    wait_d       = wait_q;
    last_grant_d = last_grant_q;

    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d      = SETUP;
          psel_d       = 1'b1;
          penable_d    = 1'b0;
          pwrite_d     = bus.req_write[grant_idx];
          paddr_d      = addr_arr[grant_idx];
          pwdata_d     = wdata_arr[grant_idx];
          last_grant_d = grant_idx;
          req_ready_d  = NREQ'(1) << grant_idx;
        end
      end
      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
        wait_d    = '0;
      end
      ACCESS: begin
        if (bus.PREADY) begin
          state_d     = IDLE;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = NREQ'(1) << last_grant_q;
          rsp_err_d   = bus.PSLVERR;
          rsp_rdata_d = pwrite_q ? '0 : bus.PRDATA;
        end else if ((TIMEOUT > 0) && (wait_q == CW'(TO_LAST))) begin
          // Watchdog: slave never answered, abort with an error response.
          state_d     = IDLE;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = NREQ'(1) << last_grant_q;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
        end else begin
          wait_d = wait_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset leaves last_grant at NREQ-1 so requester 0 wins first.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q      <= IDLE;
      psel_q       <= 1'b0;
      penable_q    <= 1'b0;
      pwrite_q     <= 1'b0;
      paddr_q      <= '0;
      pwdata_q     <= '0;
      req_ready_q  <= '0;
      rsp_valid_q  <= '0;
      rsp_rdata_q  <= '0;
      rsp_err_q    <= 1'b0;
      wait_q       <= '0;
      last_grant_q <= GW'(NREQ - 1);
    end else begin
      state_q      <= state_d;
      psel_q       <= psel_d;
      penable_q    <= penable_d;
      pwrite_q     <= pwrite_d;
      paddr_q      <= paddr_d;
      pwdata_q     <= pwdata_d;
      req_ready_q  <= req_ready_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rdata_q  <= rsp_rdata_d;
      rsp_err_q    <= rsp_err_d;
      wait_q       <= wait_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign bus.PSEL      = psel_q;
  assign bus.PENABLE   = penable_q;
  assign bus.PWRITE    = pwrite_q;
  assign bus.PADDR     = paddr_q;
  assign bus.PWDATA    = pwdata_q;
  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_rr_arbiter.sv
// Directed bench for apb_rr_arbiter: a vector table of single transfers plus
// hand-written reset, fairness and mid-transfer reset sequences.
module tb_apb_rr_arbiter;

  localparam int unsigned NREQ    = 2;
  localparam int unsigned AW      = 32;
  localparam int unsigned DW      = 32;
  localparam int unsigned TIMEOUT = 16;

  logic PCLK;
  logic PRESET;

  apb_rr_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus ();

  apb_rr_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .PCLK   (PCLK),
    .PRESET (PRESET),
    .bus    (bus.master)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  typedef struct {
    logic [1:0]  valid;
    logic [1:0]  write;
    logic        hold;
    logic [31:0] addr0;
    logic [31:0] addr1;
    logic [31:0] wdata0;
    logic [31:0] wdata1;
    int          waits;
    logic [31:0] prdata;
    logic        slverr;
    int          grant;
    logic        exp_err;
    logic [31:0] exp_rdata;
    int          exp_acc;
  } vec_t;

  int errors = 0;
  int checks = 0;
  vec_t vecs[11];

  task automatic step();
    @(posedge PCLK);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [1:0] valid, input logic [1:0] write, input logic hold,
                              input logic [31:0] a0, input logic [31:0] a1,
                              input logic [31:0] d0, input logic [31:0] d1,
                              input int waits, input logic [31:0] prdata, input logic slverr,
                              input int grant, input logic exp_err, input logic [31:0] exp_rdata,
                              input int exp_acc);
    vec_t v;
    v.valid = valid;  v.write = write;   v.hold = hold;
    v.addr0 = a0;     v.addr1 = a1;      v.wdata0 = d0;   v.wdata1 = d1;
    v.waits = waits;  v.prdata = prdata; v.slverr = slverr;
    v.grant = grant;  v.exp_err = exp_err; v.exp_rdata = exp_rdata; v.exp_acc = exp_acc;
    return v;
  endfunction

  task automatic run_vec(input int n, input vec_t v);
    int gap;
    int k;
    logic [1:0] onehot;
    onehot = 2'b01 << v.grant;
    bus.req_valid = v.valid;
    bus.req_write = v.write;
    bus.req_addr  = {v.addr1, v.addr0};
    bus.req_wdata = {v.wdata1, v.wdata0};
    bus.PREADY    = 1'b0;
    bus.PSLVERR   = 1'b0;
    bus.PRDATA    = v.prdata;

    // Grant must follow after exactly one IDLE cycle.
    gap = 0;
    do begin
      step();
      gap++;
      if (!bus.PSEL) chk($sformatf("v%0d_idle_rsp", n), 64'(bus.rsp_valid), 64'(0));
    end while (!bus.PSEL && gap < 8);
    chk($sformatf("v%0d_gap", n), 64'(gap), 64'(1));
    if (!bus.PSEL) return;

    chk($sformatf("v%0d_setup_en", n), 64'(bus.PENABLE), 64'(0));
    chk($sformatf("v%0d_ready", n), 64'(bus.req_ready), 64'(onehot));
    chk($sformatf("v%0d_paddr", n), 64'(bus.PADDR), 64'(v.grant == 1 ? v.addr1 : v.addr0));
    chk($sformatf("v%0d_pwrite", n), 64'(bus.PWRITE), 64'(v.write[v.grant]));
    chk($sformatf("v%0d_pwdata", n), 64'(bus.PWDATA), 64'(v.grant == 1 ? v.wdata1 : v.wdata0));
    if (!v.hold) bus.req_valid = v.valid & ~onehot;

    step();
    chk($sformatf("v%0d_access", n), 64'({bus.PSEL, bus.PENABLE}), 64'(2'b11));
    chk($sformatf("v%0d_ready_pulse", n), 64'(bus.req_ready), 64'(0));

    k = 1;
    forever begin
      bus.PREADY  = (k > v.waits);
      bus.PSLVERR = v.slverr;
      step();
      if (!bus.PSEL) break;
      if (k >= 40) begin
        chk($sformatf("v%0d_access_bound", n), 64'(k), 64'(v.exp_acc));
        bus.PREADY = 1'b0;
        return;
      end
      k++;
    end
    chk($sformatf("v%0d_acc_cycles", n), 64'(k), 64'(v.exp_acc));
    chk($sformatf("v%0d_penable_off", n), 64'(bus.PENABLE), 64'(0));
    chk($sformatf("v%0d_rsp_valid", n), 64'(bus.rsp_valid), 64'(onehot));
    chk($sformatf("v%0d_rsp_err", n), 64'(bus.rsp_err), 64'(v.exp_err));
    chk($sformatf("v%0d_rsp_rdata", n), 64'(bus.rsp_rdata), 64'(v.exp_rdata));
    bus.PREADY  = 1'b0;
    bus.PSLVERR = 1'b0;
  endtask

  initial begin
    //              valid  write  hold  addr0      addr1      wdata0     wdata1     waits prdata        slv  g  err  rdata         acc
    vecs[0]  = mk(2'b11, 2'b01, 1'b0, 32'h0010, 32'h0020, 32'h00A5, 32'h0000, 0,  32'h0,        1'b0, 0, 1'b0, 32'h0,        1);
    vecs[1]  = mk(2'b10, 2'b00, 1'b0, 32'h0010, 32'h0020, 32'h0000, 32'h0000, 3,  32'h1234,     1'b0, 1, 1'b0, 32'h1234,     4);
    vecs[2]  = mk(2'b01, 2'b01, 1'b0, 32'h0030, 32'h0000, 32'h005A, 32'h0000, 0,  32'h0,        1'b1, 0, 1'b1, 32'h0,        1);
    vecs[3]  = mk(2'b10, 2'b00, 1'b0, 32'h0000, 32'h0040, 32'h0000, 32'h0000, 99, 32'hDEAD,     1'b0, 1, 1'b1, 32'h0,        16);
    for (int i = 0; i < 6; i++)
      vecs[4+i] = mk(2'b11, 2'b11, 1'b1, 32'h0100, 32'h0104, 32'h0011, 32'h0022, 0, 32'h0,   1'b0, i % 2, 1'b0, 32'h0, 1);
    vecs[10] = mk(2'b10, 2'b00, 1'b0, 32'h0000, 32'h0060, 32'h0000, 32'h0000, 1,  32'hBEEF,     1'b0, 1, 1'b0, 32'hBEEF,     2);

    PRESET        = 1'b1;
    bus.req_valid = 2'b11;
    bus.req_write = 2'b00;
    bus.req_addr  = {32'h0020, 32'h0010};
    bus.req_wdata = '0;
    bus.PRDATA    = '0;
    bus.PREADY    = 1'b0;
    bus.PSLVERR   = 1'b0;

    // Reset held with requests pending: bus stays quiet.
    for (int c = 0; c < 3; c++) begin
      step();
      chk($sformatf("rst%0d_psel", c), 64'(bus.PSEL), 64'(0));
      chk($sformatf("rst%0d_penable", c), 64'(bus.PENABLE), 64'(0));
      chk($sformatf("rst%0d_ready", c), 64'(bus.req_ready), 64'(0));
      chk($sformatf("rst%0d_rsp", c), 64'(bus.rsp_valid), 64'(0));
      chk($sformatf("rst%0d_paddr", c), 64'(bus.PADDR), 64'(0));
    end
    PRESET = 1'b0;

    for (int i = 0; i < 11; i++) run_vec(i, vecs[i]);

    // Reset during ACCESS kills requester 0's transfer; arbitration restarts at 0.
    bus.req_valid = 2'b01;
    bus.req_write = 2'b00;
    bus.req_addr  = {32'h0070, 32'h0050};
    step();
    chk("mid_setup_ready", 64'(bus.req_ready), 64'(2'b01));
    bus.req_valid = 2'b00;
    step();
    chk("mid_access", 64'({bus.PSEL, bus.PENABLE}), 64'(2'b11));
    step();
    chk("mid_access_wait", 64'({bus.PSEL, bus.PENABLE}), 64'(2'b11));
    PRESET = 1'b1;
    step();
    PRESET = 1'b0;
    chk("mid_rst_bus", 64'({bus.PSEL, bus.PENABLE}), 64'(2'b00));
    chk("mid_rst_rsp", 64'(bus.rsp_valid), 64'(0));
    bus.req_valid = 2'b11;
    step();
    chk("mid_regrant_ready", 64'(bus.req_ready), 64'(2'b01));
    chk("mid_regrant_paddr", 64'(bus.PADDR), 64'(32'h0050));
    bus.req_valid = 2'b00;
    bus.PREADY    = 1'b1;
    step();
    chk("mid_regrant_norsp", 64'(bus.rsp_valid), 64'(0));
    step();
    chk("mid_regrant_rsp", 64'(bus.rsp_valid), 64'(2'b01));
    bus.PREADY = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/apb_rr_arbiter.md
Name: apb_rr_arbiter

Overview:
- Round-robin scheduler that shares one APB master port among NREQ requesters.
- Each requester posts a single read or write through a valid/ready request and a one-cycle response pulse.
- The block owns the APB SETUP/ACCESS sequencing, including wait states and PSLVERR.
- An optional watchdog aborts transfers to a slave that never asserts PREADY.

Parameters:
- NREQ, 2, number of requesters (2..8).
- AW, 32, address width.
- DW, 32, data width.
- TIMEOUT, 16, maximum ACCESS cycles before abort; 0 disables the watchdog.

Ports:
- PCLK  in  1  clock; all logic updates on the rising edge.
- PRESET  in  1  synchronous, active-high reset.
- req_valid  in  NREQ  per-requester request; held until the matching req_ready bit.
- req_write  in  NREQ  1 = write, 0 = read.
- req_addr  in  NREQ*AW  packed addresses; requester i at [i*AW +: AW].
- req_wdata  in  NREQ*DW  packed write data.
- req_ready  out  NREQ  one-cycle pulse: request accepted.
- rsp_valid  out  NREQ  one-cycle pulse: transfer complete.
- rsp_rdata  out  DW  read data; valid only with rsp_valid.
- rsp_err  out  1  PSLVERR or timeout; valid only with rsp_valid.
- PSEL  out  1  APB select.
- PENABLE  out  1  APB enable.
- PWRITE  out  1  APB direction.
- PADDR  out  AW  APB address.
- PWDATA  out  DW  APB write data.
- PRDATA  in  DW  APB read data.
- PREADY  in  1  APB ready.
- PSLVERR  in  1  APB slave error.

Behaviour:
- All outputs are registered.
- **Reset (PRESET=1 at an edge, overrides everything):**
  - state = IDLE.
  - PSEL = PENABLE = PWRITE = 0; PADDR = PWDATA = 0.
  - req_ready = rsp_valid = 0; rsp_rdata = 0; rsp_err = 0.
  - Wait counter = 0; last_grant = NREQ-1, so requester 0 wins first.
- **Reset mid-transfer:** PSEL/PENABLE drop in the next cycle. No rsp_valid is issued for the killed transfer.
- **FSM states:** IDLE, SETUP, ACCESS.
- **IDLE:**
  - If any req_valid is set, grant g = the first set bit searching from (last_grant+1) mod NREQ, upward with wrap.
  - Latch req_write[g], addr[g], wdata[g] into PWRITE/PADDR/PWDATA.
  - Set last_grant = g and go to SETUP.
  - During the SETUP cycle: PSEL=1, PENABLE=0, req_ready[g]=1 (one cycle only).
  - If no request is pending, stay in IDLE with PSEL=0.
- **SETUP:** go unconditionally to ACCESS; PENABLE=1 and PSEL stays 1.
- **ACCESS:**
  - PSEL, PENABLE, PWRITE, PADDR and PWDATA are held stable.
  - PREADY=1 at an edge → complete the transfer:
    - next state IDLE; PSEL = PENABLE = 0;
    - rsp_valid[g] = 1 for one cycle;
    - rsp_err = PSLVERR;
    - rsp_rdata = PRDATA for a read, 0 for a write.
  - PREADY=0 → increment the wait counter (cleared on entry to ACCESS).
  - If TIMEOUT>0, PREADY=0 and counter == TIMEOUT-1 at an edge → abort:
    - next state IDLE; PSEL = PENABLE = 0;
    - rsp_valid[g]=1, rsp_err=1, rsp_rdata=0.
    - ACCESS therefore lasts at most TIMEOUT cycles.
- **Latency:**
  - req_valid sampled in IDLE at edge e0 → SETUP after e0, ACCESS after e1.
  - With zero wait states, PREADY sampled at e2 → rsp_valid high after e2.
  - Each wait state adds one cycle.
  - At least one IDLE cycle separates consecutive transfers; arbitration runs in the same cycle rsp_valid is high.
- **Outside transfers:** PADDR, PWDATA and PWRITE hold their last values. rsp_rdata and rsp_err hold until the next completion.
- **Request protocol:**
  - Requesters may drop req_valid only after req_ready.
  - Changes to req_valid, req_addr or req_wdata after acceptance have no effect on the transfer in flight.
  - A requester that drops req_valid before acceptance is simply not granted.
- **Fairness:** with all requesters continuously valid, grants rotate 0,1,…,NREQ-1,0. No requester waits more than NREQ-1 transfers.
- **NREQ=1:** degenerates to a simple APB sequencer.

Test Plan:
1. Hold PRESET=1 for 3 cycles with req_valid=2'b11 → PSEL=0, PENABLE=0, req_ready=0, rsp_valid=0, PADDR=0 throughout; first grant after release goes to requester 0.
2. Write from req0 (addr 0x0010, wdata 0xA5), PREADY tied 1 → SETUP with PADDR=0x10, PWDATA=0xA5, PWRITE=1; ACCESS next cycle; rsp_valid=2'b01 two cycles after SETUP start, rsp_err=0.
3. Read from req1 (addr 0x0020), PREADY low for 3 ACCESS cycles, PRDATA=0x1234 → ACCESS lasts 4 cycles; rsp_valid=2'b10, rsp_rdata=0x1234, rsp_err=0.
4. Both requesters continuously valid for 6 transfers → req_ready sequence 01,10,01,10,01,10; exactly one IDLE cycle between transfers.
5. Error paths:
   - PSLVERR=1 with PREADY=1 on a write → rsp_err=1.
   - Read with PREADY stuck 0 and TIMEOUT=16 → abort after exactly 16 ACCESS cycles; rsp_err=1, rsp_rdata=0, PSEL low the next cycle.
6. Assert PRESET for 1 cycle during ACCESS (PREADY=0) → PSEL=PENABLE=0 the following cycle; no rsp_valid; next grant goes to requester 0.
